div_serial: RTL and testbench



---
 rtl/div_serial.sv | 142 ++++++++++++++
 tb/tb_div_serial.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_serial.sv
// rtl/div_serial.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-low reset
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend
//   opdata2_i     divisor
//   start_i       divide request, held until ready_o is seen
//   annul_i       abort an in-flight divide
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
module div_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state_q, state_d;
  logic [63:0] w_q, w_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [31:0] dvs_q, dvs_d;
  logic        ready_d;
  logic [63:0] result_d;

  // Operand magnitudes; |0x80000000| is naturally 0x80000000 unsigned.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  assign a_neg = signed_div_i & opdata1_i[31];
  assign b_neg = signed_div_i & opdata2_i[31];
  assign a_mag = a_neg ? (~opdata1_i + 32'd1) : opdata1_i;
  assign b_mag = b_neg ? (~opdata2_i + 32'd1) : opdata2_i;

  // One restoring step. The partial remainder is always below the divisor,
  // so only the shifted-out bit needs the 65th position and the stored
  // register can stay 64 bits wide.
  logic [64:0] w_sh;
  logic [32:0] trial;
  logic [63:0] w_it;
  logic [31:0] quo_fix, rem_fix;

  assign w_sh    = {w_q, 1'b0};
  assign trial   = w_sh[64:32] - {1'b0, dvs_q};
  assign w_it    = trial[32] ? w_sh[63:0] : {trial[31:0], w_sh[31:1], 1'b1};
  assign quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (~w_it[31:0] + 32'd1) : w_it[31:0];
  assign rem_fix = (sgn_q && neg1_q) ? (~w_it[63:32] + 32'd1) : w_it[63:32];

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    dvs_d    = dvs_q;
    ready_d  = ready_o;
    result_d = result_o;

    unique case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = 64'h0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'h0) begin
            state_d = BYZERO;
          end else begin
            sgn_d   = signed_div_i;
            neg1_d  = a_neg;
            neg2_d  = b_neg;
            dvs_d   = b_mag;
            w_d     = {32'h0, a_mag};
            cnt_d   = 5'd0;
            state_d = ON;
          end
        end
      end
      BYZERO: begin
        state_d  = END;
        ready_d  = 1'b1;
        result_d = 64'h0;
      end
      ON: begin
        if (annul_i) begin
          state_d = FREE;
          cnt_d   = 5'd0;
        end else begin
          w_d   = w_it;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = END;
            ready_d  = 1'b1;
            result_d = {rem_fix, quo_fix};
          end
        end
      end
      END: begin
        if (!start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = 64'h0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= FREE;
      cnt_q    <= 5'd0;
      ready_o  <= 1'b0;
      result_o <= 64'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_o  <= ready_d;
      result_o <= result_d;
    end
  end

  // Operand and working registers are don't-care after reset.
  always_ff @(posedge clk) begin
    w_q    <= w_d;
    sgn_q  <= sgn_d;
    neg1_q <= neg1_d;
    neg2_q <= neg2_d;
    dvs_q  <= dvs_d;
  end

endmodule

// File: tb/tb_div_serial.sv
// tb/tb_div_serial.sv - self-checking bench for div_serial
module tb_div_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_serial dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r, q};
  endfunction

  // Starts a divide in the current cycle, scrambles the operands once they
  // have been captured, then checks latency, result, hold and release.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input string name);
    int n;
    logic [63:0] e;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    annul_i      = 1'b0;
    start_i      = 1'b1;
    exp_q.push_back(exp);
    n = 0;
    do begin
      tick();
      n++;
      if (n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
      end
    end while (!ready_o && n < 40);
    if (!ready_o) begin
      chk({name, "_timeout"}, 64'(ready_o), 64'h1);
      void'(exp_q.pop_front());
      start_i = 1'b0;
      tick();
      return;
    end
    e = exp_q.pop_front();
    chk({name, "_latency"}, 64'(n), 64'(lat));
    chk({name, "_result"}, result_o, e);
    tick();
    chk({name, "_hold_ready"}, 64'(ready_o), 64'h1);
    chk({name, "_hold_result"}, result_o, e);
    start_i = 1'b0;
    tick();
    chk({name, "_drop_ready"}, 64'(ready_o), 64'h0);
    chk({name, "_drop_result"}, result_o, 64'h0);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    logic rose;
    int n;
    logic [63:0] e;

    vecs.push_back('{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},                33});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'h2,          {32'hFFFFFFFF, 32'hFFFFFFFD},   33});
    vecs.push_back('{1'b1, 32'h7,          32'hFFFFFFFE,   {32'h1, 32'hFFFFFFFD},          33});
    vecs.push_back('{1'b1, 32'h5,          32'h0,          64'h0,                          2});
    vecs.push_back('{1'b0, 32'h5,          32'h0,          64'h0,                          2});
    vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h0, 32'h80000000},          33});
    vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'h1,          {32'h0, 32'hFFFFFFFF},          33});
    vecs.push_back('{1'b0, 32'h5,          32'hFFFFFFFF,   {32'h5, 32'h0},                 33});
    vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h0, 32'h1},                 33});
    vecs.push_back('{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   {32'h0, 32'h1},                 33});
    vecs.push_back('{1'b1, 32'h80000000,   32'h1,          {32'h0, 32'h80000000},          33});
    vecs.push_back('{1'b0, 32'h0,          32'h5,          64'h0,                          33});
    vecs.push_back('{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   {32'hFFFFFFFE, 32'hE},          33});
    for (int i = 0; i < 10; i++) begin
      v.sgn = 1'($urandom_range(0, 1));
      v.a   = $urandom;
      v.b   = $urandom >> $urandom_range(0, 31);
      v.exp = model(v.sgn, v.a, v.b);
      v.lat = (v.b == 32'h0) ? 2 : 33;
      vecs.push_back(v);
    end

    rst = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'h0;
    opdata2_i = 32'h0;
    start_i = 1'b0;
    annul_i = 1'b0;
    tick();
    tick();
    chk("reset_ready", 64'(ready_o), 64'h0);
    chk("reset_result", result_o, 64'h0);
    rst = 1'b1;
    tick();

    foreach (vecs[i]) run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                              $sformatf("vec%0d", i));

    // Annul at T+10, fresh divide started at T+11.
    signed_div_i = 1'b0;
    opdata1_i = 32'hFFFF0000;
    opdata2_i = 32'h3;
    start_i = 1'b1;
    rose = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (ready_o) rose = 1'b1;
    end
    annul_i = 1'b1;
    start_i = 1'b0;
    tick();
    chk("annul_no_ready", 64'(rose | ready_o), 64'h0);
    chk("annul_result", result_o, 64'h0);
    run_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "annul_restart");

    // Reset at T+20 during ON.
    signed_div_i = 1'b1;
    opdata1_i = 32'h12345678;
    opdata2_i = 32'h11;
    start_i = 1'b1;
    rose = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ready_o) rose = 1'b1;
    end
    rst = 1'b0;
    start_i = 1'b0;
    tick();
    chk("rst_on_ready", 64'(ready_o), 64'h0);
    chk("rst_on_result", result_o, 64'h0);
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ready_o) rose = 1'b1;
    end
    chk("rst_on_no_ready", 64'(rose), 64'h0);

    // Reset while in END.
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd10;
    start_i = 1'b1;
    exp_q.push_back({32'd0, 32'd100});
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready_o && n < 40);
    e = exp_q.pop_front();
    chk("rst_end_ready_seen", 64'(ready_o), 64'h1);
    chk("rst_end_result", result_o, e);
    rst = 1'b0;
    start_i = 1'b0;
    tick();
    chk("rst_end_ready", 64'(ready_o), 64'h0);
    chk("rst_end_cleared", result_o, 64'h0);
    rst = 1'b1;
    tick();

    run_div(1'b1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, "post_reset");

    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
